rsa_fifo_bridge: RTL and testbench
==================================

Name: rsa_fifo_bridge

Overview:
- Downstream of the AHB-to-FIFO slave in the RSA subsystem.
- Drains 32-bit words from the forward FIFO and packs them into K-bit operands for the RSA datapath core.
- Unpacks the core's K-bit results into 32-bit words and pushes them into the backward FIFO.
- Raises rsa_finish to the AHB slave once every result word has been written back.

Parameters:
- K, 128, operand/result width in bits; multiple of 32.
- N, 16, operands per job.
- NRES, 4, results per job.
- W, K/32 (derived localparam), 32-bit words per operand.

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- rsa_start  in  1  level; job request from the AHB slave.
- rsa_finish  out  1  one-cycle pulse; job complete.
- frd_vld  in  1  forward FIFO has data.
- frd_rdy  out  1  pop forward FIFO.
- frd_dat  in  32  forward FIFO data.
- bwr_vld  out  1  push to backward FIFO.
- bwr_rdy  in  1  backward FIFO not full.
- bwr_dat  out  32  backward FIFO data.
- op_vld  out  1  operand valid to core.
- op_rdy  in  1  core accepts operand.
- op_dat  out  K  operand.
- op_idx  out  clog2(N)  operand index 0..N-1.
- op_last  out  1  high with operand N-1.
- res_vld  in  1  core result valid.
- res_rdy  out  1  result accepted.
- res_dat  in  K  result.
- busy  out  1  high in every state except IDLE and REARM.

Behaviour:
- Reset (asynchronous, HRESETn low):
  - state=IDLE.
  - All counters cleared; op_dat and packing register cleared.
  - Every output 0.
- Handshakes: a transfer occurs on a posedge where vld&rdy=1. Once vld is asserted, it and its data stay stable until the transfer.
- Packing: the first popped word goes to bits [31:0], word j to [32j+31:32j]. Unpacking uses the same order: LS word is pushed first.
- FSM states and transitions:
  - IDLE: if rsa_start=1, clear op_cnt/res_cnt/word_cnt and go to LOAD.
  - LOAD: frd_rdy=1. Each pop stores the word at word_cnt and increments word_cnt. On the pop with word_cnt=W-1, go to ISSUE next cycle and clear frd_rdy. An empty FIFO (frd_vld=0) simply stalls; there is no timeout.
  - ISSUE: op_vld=1, op_idx=op_cnt, op_last=(op_cnt==N-1). On accept, op_cnt++ and clear word_cnt. Then go to LOAD if op_cnt<N-1, else to COLLECT.
  - COLLECT: res_rdy=1. On accept, latch res_dat into the unpack register, clear res_rdy, go to UNLOAD.
  - UNLOAD: bwr_vld=1, bwr_dat=word word_cnt. Each accepted push increments word_cnt. After the push of word W-1, res_cnt++; then go to COLLECT if res_cnt<NRES-1, else to DONE. bwr_rdy=0 stalls with data held.
  - DONE: rsa_finish=1 for exactly one cycle, then REARM.
  - REARM: wait for rsa_start=0, then IDLE. A level-high rsa_start therefore never retriggers a job.
- Latency:
  - LOAD→ISSUE costs 1 cycle after the last word is popped.
  - Minimum per operand: W pops + 1 issue cycle.
  - Back-to-back pushes during UNLOAD: 1 word per cycle.
- Simultaneous events:
  - res_vld during LOAD/ISSUE is ignored (res_rdy=0); the core must hold it.
  - rsa_start deassert mid-job is ignored; the job runs to DONE.
- Reset mid-job: abandons all state. Partially packed words are lost. FIFO contents are not flushed by this block.
- Counter widths: clog2(W)+1, clog2(N)+1, clog2(NRES)+1. No wrap inside a job.

Decomposition:
- Shared package rsa_bridge_pkg holds:
  - FSM state encoding (IDLE=0, LOAD, ISSUE, COLLECT, UNLOAD, DONE, REARM);
  - word-width constant 32;
  - a clog2 helper.
- One natural sub-module, rsa_word_unpacker: holds the K-bit register, the word counter and the bwr_* handshake. It is loaded by the FSM and reports its last push.
- Packing stays inline in the top module.

Test Plan:
- Single job: set K=128, N=2, NRES=1; preload the FIFO with 8 words 0x0..0x7; hold rsa_start=1; core always ready.
  - First accepted operand: op_dat=0x00000003_00000002_00000001_00000000, op_idx=0.
  - Second accepted operand: op_idx=1 with op_last=1.
  - Return result 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA. Backward FIFO must receive AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD in that order.
  - rsa_finish is high exactly one cycle.
- FIFO starvation: frd_vld=0 for 10 cycles after word 2 → state stays in LOAD and op_vld stays 0. Packed value is correct after resume.
- Core backpressure: op_rdy=0 for 5 cycles → op_vld, op_dat and op_idx are held stable. No extra FIFO pops occur.
- Backward full: bwr_rdy toggles 1,0,0,1 during UNLOAD → bwr_dat is held while stalled, no word is duplicated, and exactly 4 pushes occur per result.
- Re-arm: rsa_start held high after DONE → no second job starts and busy=0. Drop then raise rsa_start → a new job starts with op_idx=0.
- Reset mid-ISSUE: assert HRESETn=0 → op_vld=0, busy=0 and rsa_finish=0 immediately (asynchronous). After release the block sits in IDLE.

Source files
------------

// File: rtl/rsa_bridge_pkg.sv
// Shared definitions for the RSA FIFO bridge: FSM encoding, word width and a
// constant clog2 helper usable in port and parameter declarations.
package rsa_bridge_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_COLLECT = 3'd3,
    ST_UNLOAD  = 3'd4,
    ST_DONE    = 3'd5,
    ST_REARM   = 3'd6
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rsa_word_unpacker.sv
// Holds one K-bit result and pushes it to the backward FIFO one 32-bit word
// per accepted handshake, least-significant word first.
module rsa_word_unpacker
  import rsa_bridge_pkg::*;
#(
  parameter int K = 128
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              load,
  input  logic [K-1:0]      load_dat,
  output logic              bwr_vld,
  input  logic              bwr_rdy,
  output logic [WORD_W-1:0] bwr_dat,
  output logic              last_push
);

  localparam int W   = K / WORD_W;
  localparam int WCW = clog2(W) + 1;

  logic [K-1:0]   unpack_r;
  logic [WCW-1:0] word_cnt_r;
  logic           bwr_vld_r;
  logic           push_s;
  logic           last_word_s;

  assign push_s      = bwr_vld_r & bwr_rdy;
  assign last_word_s = (word_cnt_r == WCW'(W - 1));
  assign last_push   = push_s & last_word_s;
  assign bwr_vld     = bwr_vld_r;
  assign bwr_dat     = unpack_r[WORD_W-1:0];

  // Result register shifts down one word per push so the next word sits at the output.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      unpack_r   <= '0;
      word_cnt_r <= '0;
      bwr_vld_r  <= 1'b0;
    end else if (load) begin
      unpack_r   <= load_dat;
      word_cnt_r <= '0;
      bwr_vld_r  <= 1'b1;
    end else if (push_s) begin
      unpack_r   <= unpack_r >> WORD_W;
      word_cnt_r <= word_cnt_r + WCW'(1);
      bwr_vld_r  <= ~last_word_s;
    end else begin
      unpack_r   <= unpack_r;
      word_cnt_r <= word_cnt_r;
      bwr_vld_r  <= bwr_vld_r;
    end
  end

endmodule

// File: rtl/rsa_fifo_bridge.sv
// Packs forward-FIFO words into K-bit operands for the RSA core, and returns
// the core's results word by word to the backward FIFO.
module rsa_fifo_bridge
  import rsa_bridge_pkg::*;
#(
  parameter int K    = 128,
  parameter int N    = 16,
  parameter int NRES = 4
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                rsa_start,
  output logic                rsa_finish,
  input  logic                frd_vld,
  output logic                frd_rdy,
  input  logic [WORD_W-1:0]   frd_dat,
  output logic                bwr_vld,
  input  logic                bwr_rdy,
  output logic [WORD_W-1:0]   bwr_dat,
  output logic                op_vld,
  input  logic                op_rdy,
  output logic [K-1:0]        op_dat,
  output logic [clog2(N)-1:0] op_idx,
  output logic                op_last,
  input  logic                res_vld,
  output logic                res_rdy,
  input  logic [K-1:0]        res_dat,
  output logic                busy
);

  localparam int W   = K / WORD_W;
  localparam int WCW = clog2(W) + 1;
  localparam int OCW = clog2(N) + 1;
  localparam int RCW = clog2(NRES) + 1;
  localparam int IW  = clog2(N);

  state_e         state_r, state_nxt_s;
  logic [WCW-1:0] word_cnt_r;
  logic [OCW-1:0] op_cnt_r;
  logic [RCW-1:0] res_cnt_r;
  logic [K-1:0]   pack_r;
  logic           frd_rdy_r, op_vld_r, op_last_r, res_rdy_r, busy_r, rsa_finish_r;
  logic [IW-1:0]  op_idx_r;
  logic           pop_s, op_acc_s, res_acc_s, last_push_s;

  assign pop_s     = frd_rdy_r & frd_vld;
  assign op_acc_s  = op_vld_r & op_rdy;
  assign res_acc_s = res_rdy_r & res_vld;

  assign frd_rdy    = frd_rdy_r;
  assign op_vld     = op_vld_r;
  assign op_dat     = pack_r;
  assign op_idx     = op_idx_r;
  assign op_last    = op_last_r;
  assign res_rdy    = res_rdy_r;
  assign busy       = busy_r;
  assign rsa_finish = rsa_finish_r;

  rsa_word_unpacker #(.K(K)) u_unpacker (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .load      (res_acc_s),
    .load_dat  (res_dat),
    .bwr_vld   (bwr_vld),
    .bwr_rdy   (bwr_rdy),
    .bwr_dat   (bwr_dat),
    .last_push (last_push_s)
  );

  // State register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; counter compares use pre-increment values.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:    if (rsa_start) state_nxt_s = ST_LOAD; else state_nxt_s = ST_IDLE;
      ST_LOAD:    if (pop_s && (word_cnt_r == WCW'(W - 1))) state_nxt_s = ST_ISSUE;
                  else state_nxt_s = ST_LOAD;
      ST_ISSUE:   if (!op_acc_s) state_nxt_s = ST_ISSUE;
                  else if (op_cnt_r < OCW'(N - 1)) state_nxt_s = ST_LOAD;
                  else state_nxt_s = ST_COLLECT;
      ST_COLLECT: if (res_acc_s) state_nxt_s = ST_UNLOAD; else state_nxt_s = ST_COLLECT;
      ST_UNLOAD:  if (!last_push_s) state_nxt_s = ST_UNLOAD;
                  else if (res_cnt_r < RCW'(NRES - 1)) state_nxt_s = ST_COLLECT;
                  else state_nxt_s = ST_DONE;
      ST_DONE:    state_nxt_s = ST_REARM;
      ST_REARM:   if (!rsa_start) state_nxt_s = ST_IDLE; else state_nxt_s = ST_REARM;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Job counters.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      word_cnt_r <= '0;
      op_cnt_r   <= '0;
      res_cnt_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: if (rsa_start) begin
          word_cnt_r <= '0;
          op_cnt_r   <= '0;
          res_cnt_r  <= '0;
        end
        ST_LOAD: if (pop_s) word_cnt_r <= word_cnt_r + WCW'(1);
        ST_ISSUE: if (op_acc_s) begin
          op_cnt_r   <= op_cnt_r + OCW'(1);
          word_cnt_r <= '0;
        end
        ST_UNLOAD: if (last_push_s) res_cnt_r <= res_cnt_r + RCW'(1);
        default: word_cnt_r <= word_cnt_r;
      endcase
    end
  end

  // Packing register doubles as the operand output; word j lands in bits [32j+31:32j].
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pack_r <= '0;
    end else begin
      for (int j = 0; j < W; j++) begin
        if (pop_s && (word_cnt_r == WCW'(j))) pack_r[WORD_W*j +: WORD_W] <= frd_dat;
      end
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      frd_rdy_r    <= 1'b0;
      op_vld_r     <= 1'b0;
      op_idx_r     <= '0;
      op_last_r    <= 1'b0;
      res_rdy_r    <= 1'b0;
      busy_r       <= 1'b0;
      rsa_finish_r <= 1'b0;
    end else begin
      frd_rdy_r    <= (state_nxt_s == ST_LOAD);
      op_vld_r     <= (state_nxt_s == ST_ISSUE);
      op_idx_r     <= (state_nxt_s == ST_ISSUE) ? op_cnt_r[IW-1:0] : '0;
      op_last_r    <= (state_nxt_s == ST_ISSUE) && (op_cnt_r == OCW'(N - 1));
      res_rdy_r    <= (state_nxt_s == ST_COLLECT);
      busy_r       <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_REARM);
      rsa_finish_r <= (state_nxt_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_rsa_fifo_bridge.sv
// Directed self-checking bench for rsa_fifo_bridge with K=128, N=2, NRES=1.
module tb_rsa_fifo_bridge;

  logic         HCLK, HRESETn, rsa_start, rsa_finish;
  logic         frd_vld, frd_rdy, bwr_vld, bwr_rdy;
  logic [31:0]  frd_dat, bwr_dat;
  logic         op_vld, op_rdy, op_last, res_vld, res_rdy, busy;
  logic [127:0] op_dat, res_dat;
  logic [0:0]   op_idx;

  rsa_fifo_bridge #(.K(128), .N(2), .NRES(1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .rsa_start(rsa_start), .rsa_finish(rsa_finish),
    .frd_vld(frd_vld), .frd_rdy(frd_rdy), .frd_dat(frd_dat),
    .bwr_vld(bwr_vld), .bwr_rdy(bwr_rdy), .bwr_dat(bwr_dat),
    .op_vld(op_vld), .op_rdy(op_rdy), .op_dat(op_dat), .op_idx(op_idx), .op_last(op_last),
    .res_vld(res_vld), .res_rdy(res_rdy), .res_dat(res_dat), .busy(busy)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0]  fw [0:31];
  int           fw_n = 0, rd_ptr = 0;
  logic         starve = 1'b0;
  logic [127:0] opd [0:7];
  logic [0:0]   opi [0:7];
  logic         opl [0:7];
  int           op_n = 0;
  logic [31:0]  bq [0:15];
  int           bq_n = 0;
  int           fin_cnt = 0;
  logic [31:0]  held;
  logic         pat [0:5];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd_fifo();
    frd_vld = !starve && (rd_ptr < fw_n);
    frd_dat = frd_vld ? fw[rd_ptr] : 32'h0;
  endtask

  // One clock: handshakes are judged on the settled pre-edge values.
  task automatic cyc();
    logic fpop, oacc, racc, bpush;
    logic [127:0] od;
    logic [0:0] oi;
    logic ol;
    logic [31:0] bd;
    fpop = frd_vld && frd_rdy; oacc = op_vld && op_rdy;
    racc = res_vld && res_rdy; bpush = bwr_vld && bwr_rdy;
    od = op_dat; oi = op_idx; ol = op_last; bd = bwr_dat;
    if (rsa_finish) fin_cnt++;
    @(posedge HCLK); #1;
    if (fpop) rd_ptr++;
    if (oacc) begin opd[op_n] = od; opi[op_n] = oi; opl[op_n] = ol; op_n++; end
    if (racc) res_vld = 1'b0;
    if (bpush) begin bq[bq_n] = bd; bq_n++; end
    upd_fifo();
  endtask

  initial begin
    HRESETn = 1'b0; rsa_start = 1'b0; op_rdy = 1'b0; res_vld = 1'b0;
    res_dat = 128'h0; bwr_rdy = 1'b0;
    upd_fifo();
    repeat (3) cyc();
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {frd_rdy, op_vld, op_last, res_rdy, bwr_vld, rsa_finish}, 6'b0);
    chk("rst_op_dat", op_dat, 128'h0);
    HRESETn = 1'b1;

    // Job 1: words 0..7, starvation after word 2, core backpressure, stalled unload.
    for (int i = 0; i < 8; i++) fw[i] = i;
    fw_n = 8;
    rsa_start = 1'b1;
    res_dat = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    res_vld = 1'b1;
    upd_fifo();
    for (int i = 0; i < 40 && rd_ptr != 3; i++) cyc();
    chk("reach_word3", rd_ptr, 3);
    starve = 1'b1; upd_fifo();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("starve_load", {frd_rdy, busy, op_vld, res_rdy}, 4'b1100);
    end
    chk("starve_no_pop", rd_ptr, 3);
    starve = 1'b0; upd_fifo();
    for (int i = 0; i < 20 && !op_vld; i++) cyc();
    chk("op0_vld", op_vld, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_vld", {op_vld, frd_rdy}, 2'b10);
      chk("bp_dat", op_dat, 128'h00000003_00000002_00000001_00000000);
      chk("bp_idx", op_idx, 1'b0);
    end
    chk("bp_no_pop", rd_ptr, 4);
    op_rdy = 1'b1;
    for (int i = 0; i < 40 && op_n < 2; i++) cyc();
    chk("op_count", op_n, 2);
    chk("op0_dat", opd[0], 128'h00000003_00000002_00000001_00000000);
    chk("op0_idx_last", {opi[0], opl[0]}, 2'b00);
    chk("op1_dat", opd[1], 128'h00000007_00000006_00000005_00000004);
    chk("op1_idx_last", {opi[1], opl[1]}, 2'b11);

    for (int i = 0; i < 20 && !bwr_vld; i++) cyc();
    chk("bwr_vld_up", bwr_vld, 1'b1);
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bwr_rdy = pat[i];
      held = bwr_dat;
      cyc();
      if (!pat[i]) chk("stall_hold", {bwr_vld, bwr_dat}, {1'b1, held});
    end
    bwr_rdy = 1'b1;
    chk("push_count", bq_n, 4);
    chk("push_words", {bq[0], bq[1], bq[2], bq[3]},
        128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    chk("done_state", {rsa_finish, busy, bwr_vld}, 3'b110);
    cyc();
    chk("rearm_state", {rsa_finish, busy}, 2'b00);

    // rsa_start still high: must not retrigger.
    for (int i = 8; i < 16; i++) fw[i] = 32'h10 + i - 8;
    fw_n = 16; upd_fifo();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("no_retrigger", {busy, frd_rdy}, 2'b00);
    end
    chk("fin_once", fin_cnt, 1);
    chk("no_extra_push", bq_n, 4);
    chk("rearm_no_pop", rd_ptr, 8);

    // Drop and raise rsa_start: second job.
    rsa_start = 1'b0;
    repeat (2) cyc();
    rsa_start = 1'b1;
    for (int i = 0; i < 40 && op_n < 3; i++) cyc();
    chk("job2_op_count", op_n, 3);
    chk("job2_op0_dat", opd[2], 128'h00000013_00000012_00000011_00000010);
    chk("job2_op0_idx", opi[2], 1'b0);
    op_rdy = 1'b0;
    for (int i = 0; i < 40 && !(op_vld && op_idx == 1'b1); i++) cyc();
    chk("job2_issue1", {op_vld, op_idx, op_last}, 3'b111);

    // Asynchronous reset in the middle of ISSUE.
    #2 HRESETn = 1'b0;
    #1;
    chk("arst_outs", {op_vld, busy, rsa_finish, frd_rdy}, 4'b0000);
    repeat (2) cyc();
    HRESETn = 1'b1; rsa_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_rst_idle", {busy, frd_rdy, op_vld}, 3'b000);
    end
    rsa_start = 1'b1;
    cyc();
    chk("post_rst_start", {busy, frd_rdy, op_idx}, 3'b110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
